// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM transmitter: channel count, select width,
// FSM state type and a counter-width helper.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_term_cnt.sv
// Loadable up-counter that flags when it sits on its terminal value TERM.
// Load has priority over increment.
module tdm_term_cnt #(
  parameter int W    = 1,
  parameter int TERM = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic         done_o
);

  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, step, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TERM_V);

endmodule

// File: rtl/tdm_mux8.sv
// Sequential 8:1 time-division multiplexer: snapshots d at frame start and
// sends each channel for DWELL cycles with its select code, then FRAME_GAP idle cycles.
module tdm_mux8
  import tdm_pkg::*;
#(
  parameter int DWELL     = 1,
  parameter int FRAME_GAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] d,
  output logic              out,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic              frame_start,
  output logic              busy
);

  localparam int DW_W    = cnt_width(DWELL);
  localparam int GP_W    = cnt_width(FRAME_GAP + 1);
  localparam int GP_TERM = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

  state_t state_q, state_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              out_q, out_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;

  logic             dwell_done_s;
  logic             gap_done_s;
  logic             last_slot_s;
  logic             frame_end_s;
  logic             restart_pt_s;
  logic             load_frame_s;
  logic [SEL_W-1:0] next_sel_s;

  assign last_slot_s  = (sel_q == LAST_SEL);
  assign next_sel_s   = sel_q + ONE_SEL;
  assign frame_end_s  = (state_q == SEND) && dwell_done_s && last_slot_s;
  // Without a gap the restart decision is taken on the last dwell cycle of slot 7.
  assign restart_pt_s = (FRAME_GAP == 0) ? frame_end_s
                                         : ((state_q == GAP) && gap_done_s);
  assign load_frame_s = en && ((state_q == IDLE) || restart_pt_s);

  tdm_term_cnt #(.W(DW_W), .TERM(DWELL - 1)) u_dwell_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     ((state_q != SEND) || dwell_done_s),
    .load_val_i ({DW_W{1'b0}}),
    .inc_i      (state_q == SEND),
    .done_o     (dwell_done_s)
  );

  tdm_term_cnt #(.W(GP_W), .TERM(GP_TERM)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     ((state_q != GAP) || gap_done_s),
    .load_val_i ({GP_W{1'b0}}),
    .inc_i      (state_q == GAP),
    .done_o     (gap_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = SEND;
        else    state_d = IDLE;
      end
      SEND: begin
        if (frame_end_s) begin
          if (FRAME_GAP > 0) state_d = GAP;
          else if (en)       state_d = SEND;
          else               state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          if (en) state_d = SEND;
          else    state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and shadow next values; frame_start is a one-cycle strobe.
  always_comb begin
    shadow_d = shadow_q;
    sel_d    = sel_q;
    out_d    = out_q;
    fs_d     = 1'b0;
    busy_d   = busy_q;
    if (load_frame_s) begin
      shadow_d = d;
      sel_d    = '0;
      out_d    = d[0];
      fs_d     = 1'b1;
      busy_d   = 1'b1;
    end else if ((state_q == SEND) && dwell_done_s && !last_slot_s) begin
      sel_d = next_sel_s;
      out_d = shadow_q[next_sel_s];
    end else if (frame_end_s || restart_pt_s) begin
      sel_d  = '0;
      out_d  = 1'b0;
      busy_d = 1'b0;
    end else begin
      sel_d = sel_q;
    end
  end

  // Output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      sel_q    <= '0;
      out_q    <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      out_q    <= out_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
    end
  end

  assign out          = out_q;
  assign {s2, s1, s0} = sel_q;
  assign frame_start  = fs_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8: two instances (DWELL=1/GAP=0 and DWELL=2/GAP=2) compared
// every cycle against a frame-position reference model.
module tb_tdm_mux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] d_a, d_b;
  logic       out_a, s0_a, s1_a, s2_a, fs_a, busy_a;
  logic       out_b, s0_b, s1_b, s2_b, fs_b, busy_b;

  int         checks = 0;
  int         errors = 0;
  int         pos [2];
  logic [7:0] sh  [2];

  always #5 clk = ~clk;

  tdm_mux8 #(.DWELL(1), .FRAME_GAP(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .d(d_a), .out(out_a),
    .s0(s0_a), .s1(s1_a), .s2(s2_a), .frame_start(fs_a), .busy(busy_a)
  );

  tdm_mux8 #(.DWELL(2), .FRAME_GAP(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .d(d_b), .out(out_b),
    .s0(s0_b), .s1(s1_b), .s2(s2_b), .frame_start(fs_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {frame_start, busy, sel[2:0], out} for frame position p (-1 = idle).
  function automatic logic [5:0] expect_out(input int p, input logic [7:0] s, input int dw);
    int slot;
    if (p < 0 || p >= 8 * dw) return 6'd0;
    slot = p / dw;
    return {(p == 0), 1'b1, 3'(slot), s[slot]};
  endfunction

  // Advance one instance's model by one clock edge.
  task automatic model_step(input int i, input logic e, input logic [7:0] dv,
                            input int dw, input int gp);
    if (pos[i] < 0) begin
      if (e) begin
        pos[i] = 0;
        sh[i]  = dv;
      end
    end else begin
      pos[i]++;
      if (pos[i] == 8 * dw + gp) begin
        if (e) begin
          pos[i] = 0;
          sh[i]  = dv;
        end else begin
          pos[i] = -1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, en_a, d_a, 1, 0);
    model_step(1, en_b, d_b, 2, 2);
    @(negedge clk);
    check_eq("dut_a", {fs_a, busy_a, s2_a, s1_a, s0_a, out_a}, expect_out(pos[0], sh[0], 1));
    check_eq("dut_b", {fs_b, busy_b, s2_b, s1_b, s0_b, out_b}, expect_out(pos[1], sh[1], 2));
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    d_a   = 8'h00;
    d_b   = 8'h00;
    pos   = '{-1, -1};
    sh    = '{8'h00, 8'h00};
    repeat (2) @(negedge clk);
    check_eq("reset_a", {fs_a, busy_a, s2_a, s1_a, s0_a, out_a}, 32'd0);
    check_eq("reset_b", {fs_b, busy_b, s2_b, s1_b, s0_b, out_b}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single pulse with A5, then idle.
    en_a = 1'b1; d_a = 8'hA5;
    step();
    en_a = 1'b0;
    repeat (11) step();

    // d changes mid-frame must not affect the transmitted bits.
    en_a = 1'b1; d_a = 8'hA5;
    step();
    en_a = 1'b0;
    step();
    d_a = 8'h00;
    repeat (9) step();

    // Back-to-back frames with dwell and gap on instance B.
    en_b = 1'b1;
    repeat (45) begin
      d_b = 8'($urandom);
      step();
    end
    en_b = 1'b0;
    repeat (20) step();

    // Asynchronous reset in slot 3, then restart.
    en_a = 1'b1; d_a = 8'h3C;
    step();
    en_a = 1'b0;
    repeat (3) step();
    check_eq("slot3_reached", 32'(pos[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", {fs_a, busy_a, s2_a, s1_a, s0_a, out_a}, 32'd0);
    check_eq("async_rst_b", {fs_b, busy_b, s2_b, s1_b, s0_b, out_b}, 32'd0);
    pos = '{-1, -1};
    rst_n = 1'b1;
    en_a  = 1'b1; d_a = 8'h96;
    step();
    en_a = 1'b0;
    repeat (9) step();

    // en dropped during slot 4.
    en_a = 1'b1; d_a = 8'($urandom);
    repeat (5) step();
    en_a = 1'b0;
    repeat (10) step();

    // Randomized traffic on both instances.
    repeat (400) begin
      en_a = ($urandom_range(0, 3) == 0);
      en_b = ($urandom_range(0, 2) != 0);
      d_a  = 8'($urandom);
      d_b  = 8'($urandom);
      step();
    end
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
